rst_req_ctrl: RTL and testbench

//   Collects reset requests from blocks (software, watchdog, external) and drives
//   per-domain reset-request lines back into the reset/clock unit.
//   On any unmasked request: asserts all domain resets, holds them for HOLD_CYCLES,

---
 rtl/rst_req_ctrl.sv | 141 ++++++++++++++
 tb/tb_rst_req_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rst_req_ctrl.sv
// Reset-request collector: merges unmasked requests, holds every domain in reset,
// then releases domains one at a time with a fixed stagger and reports the cause.
module rst_req_ctrl #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_DOM        = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] req_mask_i,
  input  logic               cause_clr_i,
  output logic [NUM_DOM-1:0] dom_rst_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [NUM_REQ-1:0] cause_o,
  output logic [7:0]         rst_cnt_o
);

  localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = $clog2(NUM_DOM) + 1;

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DOM - 1);
  localparam logic [NUM_DOM-1:0] ALL_DOM   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               done_q, done_d;
  logic [NUM_REQ-1:0] cause_q, cause_d;
  logic [7:0]         rst_cnt_q, rst_cnt_d;
  logic [NUM_REQ-1:0] acc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    acc       = req_i & ~req_mask_i;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dom_d     = dom_q;
    done_d    = 1'b0;
    rst_cnt_d = rst_cnt_q;
    // A clear and a new request on the same edge leave the new bits set
    cause_d   = (cause_clr_i ? '0 : cause_q) | acc;

    case (state_q)
      IDLE: begin
        dom_d = '0;
        if (|acc) begin
          state_d   = ASSERT;
          cnt_d     = '0;
          dom_d     = ALL_DOM;
          rst_cnt_d = sat_inc(rst_cnt_q);
        end
      end
      ASSERT: begin
        dom_d = ALL_DOM;
        if (|acc) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          dom_d = ALL_DOM << 1;
          cnt_d = '0;
          idx_d = IDX_W'(1);
          if (NUM_DOM == 1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (|acc) begin
          state_d   = ASSERT;
          cnt_d     = '0;
          dom_d     = ALL_DOM;
          rst_cnt_d = sat_inc(rst_cnt_q);
        end else if (cnt_q == STAG_LAST) begin
          // Domains drop lowest index first, so a left shift frees the next one
          dom_d = dom_q << 1;
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
        dom_d   = ALL_DOM;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      dom_q     <= ALL_DOM;
      done_q    <= 1'b0;
      cause_q   <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dom_q     <= dom_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign dom_rst_o = dom_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign cause_o   = cause_q;
  assign rst_cnt_o = rst_cnt_q;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Scoreboard bench for rst_req_ctrl: expected output words are queued per cycle as
// stimulus is planned and compared on the falling edge when that cycle comes up.
module tb_rst_req_ctrl;
  localparam int HOLD = 16;
  localparam int STG  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic [3:0] mask = 4'b0;
  logic       clr = 1'b0;
  logic [2:0] dom;
  logic       busy, done;
  logic [3:0] cause;
  logic [7:0] cnt;

  rst_req_ctrl #(
    .NUM_REQ(4), .NUM_DOM(3), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STG)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_mask_i(mask), .cause_clr_i(clr),
    .dom_rst_o(dom), .busy_o(busy), .done_o(done), .cause_o(cause), .rst_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  // At a falling edge cyc names the cycle being observed; inputs set then are
  // sampled at the rising edge that ends that cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [16:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [16:0] got;
  assign got = {dom, busy, done, cause, cnt};

  // {dom, busy, done, cause, cnt}; idle up to cycle n, then the release sequence
  // whose first domain drops in cycle t0
  function automatic logic [16:0] expv(int m, int n, int t0, logic [3:0] cb,
                                       logic [3:0] ca, logic [7:0] kb, logic [7:0] ka);
    logic [4:0] s;
    if (m <= n) return {5'b00000, cb, kb};
    if (m < t0)                s = 5'b11110;
    else if (m < t0 + STG)     s = 5'b11010;
    else if (m < t0 + 2*STG)   s = 5'b10010;
    else if (m == t0 + 2*STG)  s = 5'b00001;
    else                       s = 5'b00000;
    return {s, ca, ka};
  endfunction

  task automatic push(input int c, input logic [16:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    int c, t0, len;
    exp_t e;
    c = cyc; t0 = c + 3 + HOLD; len = 40;
    for (int m = c + 1; m <= c + len; m++) push(m, expv(m, c, t0, 4'b0, 4'b0, 8'd0, 8'd0));
    for (int i = 0; i < len; i++) begin
      rst = (cyc < c + 3);
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || got !== e.val) begin
          errors++;
          $display("FAIL reset cyc=%0d got=%b exp=%b (exp cyc %0d)", cyc, got, e.val, e.cyc);
        end
      end
    end
  endtask

  task automatic test_request();
    int c, n, t0, len;
    exp_t e;
    c = cyc; n = c + 1; t0 = n + 1 + HOLD; len = t0 + 2*STG + 3 - c;
    for (int m = c + 1; m <= c + len; m++) push(m, expv(m, n, t0, 4'b0, 4'b0100, 8'd0, 8'd1));
    for (int i = 0; i < len; i++) begin
      req = (cyc == n) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || got !== e.val) begin
          errors++;
          $display("FAIL request cyc=%0d got=%b exp=%b (exp cyc %0d)", cyc, got, e.val, e.cyc);
        end
      end
    end
  endtask

  task automatic test_mask();
    int c, n, len;
    exp_t e;
    c = cyc; n = c + 1; len = 12;
    for (int m = c + 1; m <= c + len; m++)
      push(m, expv(m, c + 1000, 0, 4'b0100, 4'b0100, 8'd1, 8'd1));
    for (int i = 0; i < len; i++) begin
      mask = 4'b0010;
      req  = (cyc == n) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || got !== e.val) begin
          errors++;
          $display("FAIL mask cyc=%0d got=%b exp=%b (exp cyc %0d)", cyc, got, e.val, e.cyc);
        end
      end
    end
    mask = 4'b0000;
  endtask

  task automatic test_level();
    int c, n, t0, len;
    exp_t e;
    c = cyc; n = c + 1; t0 = n + 39 + 1 + HOLD; len = t0 + 2*STG + 3 - c;
    for (int m = c + 1; m <= c + len; m++)
      push(m, expv(m, n, t0, 4'b0100, 4'b0101, 8'd1, 8'd2));
    for (int i = 0; i < len; i++) begin
      req = (cyc >= n && cyc < n + 40) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || got !== e.val) begin
          errors++;
          $display("FAIL level cyc=%0d got=%b exp=%b (exp cyc %0d)", cyc, got, e.val, e.cyc);
        end
      end
    end
  endtask

  task automatic test_abort();
    int c, n, t0, a, t1, len;
    exp_t e;
    c = cyc; n = c + 1; t0 = n + 1 + HOLD; a = t0 + 10; t1 = a + 1 + HOLD;
    len = t1 + 2*STG + 3 - c;
    for (int m = c + 1; m <= c + len; m++) begin
      if (m <= a) push(m, expv(m, n, t0, 4'b0101, 4'b0101, 8'd2, 8'd3));
      else        push(m, expv(m, a, t1, 4'b0101, 4'b1101, 8'd3, 8'd4));
    end
    for (int i = 0; i < len; i++) begin
      req = (cyc == n) ? 4'b0100 : (cyc == a) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || got !== e.val) begin
          errors++;
          $display("FAIL abort cyc=%0d got=%b exp=%b (exp cyc %0d)", cyc, got, e.val, e.cyc);
        end
      end
    end
  endtask

  task automatic test_cause_clr();
    int c, n, t0, len;
    exp_t e;
    c = cyc; n = c + 1; t0 = n + 1 + HOLD; len = t0 + 2*STG + 3 - c;
    for (int m = c + 1; m <= c + len; m++) begin
      if (m <= n + 3) push(m, expv(m, n, t0, 4'b1101, 4'b0100, 8'd4, 8'd5));
      else            push(m, expv(m, n, t0, 4'b1101, 4'b0000, 8'd4, 8'd5));
    end
    for (int i = 0; i < len; i++) begin
      req = (cyc == n) ? 4'b0100 : 4'b0000;
      clr = (cyc == n || cyc == n + 3);
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || got !== e.val) begin
          errors++;
          $display("FAIL cause_clr cyc=%0d got=%b exp=%b (exp cyc %0d)", cyc, got, e.val, e.cyc);
        end
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_saturation();
    int c, n;
    logic [7:0] k;
    exp_t e;
    for (int ev = 0; ev < 256; ev++) begin
      c = cyc; n = c + 1;
      k = (ev + 6 > 255) ? 8'd255 : 8'(ev + 6);
      push(n + 1, {5'b11110, 4'b0100, k});
      push(n + 1 + HOLD + 2*STG, {5'b00001, 4'b0100, k});
      for (int i = 0; i < HOLD + 2*STG + 4; i++) begin
        req = (cyc == n) ? 4'b0100 : 4'b0000;
        @(negedge clk);
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front(); checks++;
          if (e.cyc != cyc || got !== e.val) begin
            errors++;
            $display("FAIL saturation ev=%0d cyc=%0d got=%b exp=%b", ev, cyc, got, e.val);
          end
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_request();
    test_mask();
    test_level();
    test_abort();
    test_cause_clr();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
